// File: rtl/pocket_call_ctrl.sv
// Pocket-call controller: the player picks a target hole (1..6) with key pulses, locks it, and
// the next pocketed ball is judged against it. Drives the hole number into the overlay (0 = none).
//
// state  | meaning
// IDLE   | no call active, nothing drawn
// SELECT | player choosing a hole, number blinks
// LOCKED | choice confirmed, waiting for a pocketed ball
// RESULT | call judged, locked number shown for RESULT_FRAMES frames

module pocket_call_ctrl #(
   parameter int BLINK_FRAMES  = 16,
   parameter int RESULT_FRAMES = 120,
   parameter int DEFAULT_HOLE  = 1
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       callRequest,
   input  logic       abortCall,
   input  logic       keyLeftP,
   input  logic       keyRightP,
   input  logic       keyEnterP,
   input  logic       ballPocketed,
   input  logic [2:0] pocketedHole,
   output logic [2:0] holeNumber,
   output logic       callLocked,
   output logic       callDone,
   output logic       callSuccess
);

   localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);
   localparam logic [7:0] RESULT_LAST = 8'(RESULT_FRAMES - 1);
   localparam logic [2:0] SEL_DEFAULT = 3'(DEFAULT_HOLE);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_LOCKED = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       blink_on_q, blink_on_d;
   logic [2:0] hole_q, hole_d;
   logic       locked_q, locked_d;
   logic       done_q, done_d;
   logic       success_q, success_d;

   logic       key_any;
   logic       key_move;
   logic [2:0] sel_next;
   logic [2:0] sel_prev;

   assign key_any  = keyLeftP | keyRightP;
   assign key_move = keyLeftP ^ keyRightP;

   // Wrap arithmetic also pulls any out-of-range value back into 1..6.
   always_comb begin
      sel_next = (sel_q >= 3'd6 || sel_q == 3'd0) ? 3'd1 : sel_q + 3'd1;
      sel_prev = (sel_q <= 3'd1 || sel_q > 3'd6)  ? 3'd6 : sel_q - 3'd1;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= ST_IDLE;
         sel_q       <= SEL_DEFAULT;
         frame_cnt_q <= 8'd0;
         blink_on_q  <= 1'b1;
         hole_q      <= 3'd0;
         locked_q    <= 1'b0;
         done_q      <= 1'b0;
         success_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         frame_cnt_q <= frame_cnt_d;
         blink_on_q  <= blink_on_d;
         hole_q      <= hole_d;
         locked_q    <= locked_d;
         done_q      <= done_d;
         success_q   <= success_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      frame_cnt_d = frame_cnt_q;
      blink_on_d  = blink_on_q;
      done_d      = 1'b0;
      success_d   = success_q;

      if (abortCall) begin
         state_d     = ST_IDLE;
         frame_cnt_d = 8'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (callRequest) begin
                  state_d     = ST_SELECT;
                  sel_d       = SEL_DEFAULT;
                  frame_cnt_d = 8'd0;
                  blink_on_d  = 1'b1;
                  success_d   = 1'b0;
               end
            end
            ST_SELECT: begin
               if (keyEnterP) begin
                  state_d     = ST_LOCKED;
                  frame_cnt_d = 8'd0;
               end else if (key_any) begin
                  // Any key press restarts the blink with the number visible.
                  frame_cnt_d = 8'd0;
                  blink_on_d  = 1'b1;
                  if (key_move) begin
                     sel_d = keyRightP ? sel_next : sel_prev;
                  end
               end else if (startOfFrame) begin
                  if (frame_cnt_q == BLINK_LAST) begin
                     frame_cnt_d = 8'd0;
                     blink_on_d  = ~blink_on_q;
                  end else begin
                     frame_cnt_d = frame_cnt_q + 8'd1;
                  end
               end
            end
            ST_LOCKED: begin
               if (ballPocketed) begin
                  state_d     = ST_RESULT;
                  done_d      = 1'b1;
                  success_d   = (pocketedHole == sel_q);
                  frame_cnt_d = 8'd0;
               end
            end
            ST_RESULT: begin
               if (startOfFrame) begin
                  if (frame_cnt_q == RESULT_LAST) begin
                     state_d     = ST_IDLE;
                     frame_cnt_d = 8'd0;
                  end else begin
                     frame_cnt_d = frame_cnt_q + 8'd1;
                  end
               end
            end
            default: begin
               state_d     = ST_IDLE;
               frame_cnt_d = 8'd0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      hole_d   = 3'd0;
      locked_d = 1'b0;
      unique case (state_d)
         ST_IDLE:   hole_d = 3'd0;
         ST_SELECT: hole_d = blink_on_d ? sel_d : 3'd0;
         ST_LOCKED: begin
            hole_d   = sel_d;
            locked_d = 1'b1;
         end
         ST_RESULT: hole_d = sel_d;
         default:   hole_d = 3'd0;
      endcase
   end

   assign holeNumber  = hole_q;
   assign callLocked  = locked_q;
   assign callDone    = done_q;
   assign callSuccess = success_q;

endmodule

// File: tb/tb_pocket_call_ctrl.sv
// Directed bench for pocket_call_ctrl: selection, blinking, locking, judging, abort and reset.

module tb_pocket_call_ctrl;

   logic       clk;
   logic       resetN;
   logic       startOfFrame;
   logic       callRequest;
   logic       abortCall;
   logic       keyLeftP;
   logic       keyRightP;
   logic       keyEnterP;
   logic       ballPocketed;
   logic [2:0] pocketedHole;
   logic [2:0] holeNumber;
   logic       callLocked;
   logic       callDone;
   logic       callSuccess;

   int errors = 0;
   int checks = 0;

   pocket_call_ctrl #(
      .BLINK_FRAMES (16),
      .RESULT_FRAMES(120),
      .DEFAULT_HOLE (1)
   ) dut (
      .clk         (clk),
      .resetN      (resetN),
      .startOfFrame(startOfFrame),
      .callRequest (callRequest),
      .abortCall   (abortCall),
      .keyLeftP    (keyLeftP),
      .keyRightP   (keyRightP),
      .keyEnterP   (keyEnterP),
      .ballPocketed(ballPocketed),
      .pocketedHole(pocketedHole),
      .holeNumber  (holeNumber),
      .callLocked  (callLocked),
      .callDone    (callDone),
      .callSuccess (callSuccess)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock of stimulus: inputs set at negedge, cleared and outputs sampled 1 after posedge.
   task automatic drive(input logic sof, input logic req, input logic abt, input logic kl,
                        input logic kr, input logic ke, input logic bp, input logic [2:0] ph);
      @(negedge clk);
      startOfFrame = sof; callRequest = req; abortCall = abt; keyLeftP = kl;
      keyRightP = kr; keyEnterP = ke; ballPocketed = bp; pocketedHole = ph;
      @(posedge clk);
      #1;
      startOfFrame = 0; callRequest = 0; abortCall = 0; keyLeftP = 0;
      keyRightP = 0; keyEnterP = 0; ballPocketed = 0; pocketedHole = 0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 3'd0);
   endtask

   task automatic test_reset;
      resetN = 0;
      startOfFrame = 0; callRequest = 0; abortCall = 0; keyLeftP = 0;
      keyRightP = 0; keyEnterP = 0; ballPocketed = 0; pocketedHole = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL reset_hole got=%0d exp=0", holeNumber); end
      checks++; if (callLocked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", callLocked); end
      checks++; if (callDone !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", callDone); end
      checks++; if (callSuccess !== 1'b0) begin errors++; $display("FAIL reset_success got=%b exp=0", callSuccess); end
      @(negedge clk);
      resetN = 1;
   endtask

   task automatic test_blink;
      drive(0, 0, 0, 0, 0, 0, 0, 3'd0);
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL idle_hole got=%0d exp=0", holeNumber); end
      drive(0, 1, 0, 0, 0, 0, 0, 3'd0);
      checks++; if (holeNumber !== 3'd1) begin errors++; $display("FAIL select_default got=%0d exp=1", holeNumber); end
      frames(15);
      checks++; if (holeNumber !== 3'd1) begin errors++; $display("FAIL blink_15 got=%0d exp=1", holeNumber); end
      frames(1);
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL blink_off got=%0d exp=0", holeNumber); end
      frames(16);
      checks++; if (holeNumber !== 3'd1) begin errors++; $display("FAIL blink_on_again got=%0d exp=1", holeNumber); end
   endtask

   task automatic test_keys;
      drive(0, 0, 0, 1, 0, 0, 0, 3'd0);
      checks++; if (holeNumber !== 3'd6) begin errors++; $display("FAIL left_wrap got=%0d exp=6", holeNumber); end
      frames(16);
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL blink_off_at6 got=%0d exp=0", holeNumber); end
      drive(0, 0, 0, 0, 1, 0, 0, 3'd0);
      checks++; if (holeNumber !== 3'd1) begin errors++; $display("FAIL right_wrap_forces_on got=%0d exp=1", holeNumber); end
      drive(0, 0, 0, 0, 1, 0, 0, 3'd0);
      checks++; if (holeNumber !== 3'd2) begin errors++; $display("FAIL right_to_2 got=%0d exp=2", holeNumber); end
      frames(15);
      checks++; if (holeNumber !== 3'd2) begin errors++; $display("FAIL key_clears_cnt got=%0d exp=2", holeNumber); end
      frames(1);
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL blink_off_at2 got=%0d exp=0", holeNumber); end
      drive(1, 0, 0, 0, 1, 0, 0, 3'd0);
      checks++; if (holeNumber !== 3'd3) begin errors++; $display("FAIL key_with_sof got=%0d exp=3", holeNumber); end
      frames(15);
      checks++; if (holeNumber !== 3'd3) begin errors++; $display("FAIL sof_key_cleared got=%0d exp=3", holeNumber); end
      frames(1);
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL blink_off_at3 got=%0d exp=0", holeNumber); end
   endtask

   task automatic test_hit;
      drive(0, 0, 1, 0, 0, 0, 0, 3'd0);
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL abort_select_hole got=%0d exp=0", holeNumber); end
      drive(0, 1, 0, 0, 0, 0, 0, 3'd0);
      repeat (3) drive(0, 0, 0, 0, 1, 0, 0, 3'd0);
      checks++; if (holeNumber !== 3'd4) begin errors++; $display("FAIL sel_4 got=%0d exp=4", holeNumber); end
      drive(0, 0, 0, 0, 0, 1, 0, 3'd0);
      checks++; if (callLocked !== 1'b1) begin errors++; $display("FAIL lock_flag got=%b exp=1", callLocked); end
      checks++; if (holeNumber !== 3'd4) begin errors++; $display("FAIL lock_hole got=%0d exp=4", holeNumber); end
      frames(100);
      checks++; if (holeNumber !== 3'd4) begin errors++; $display("FAIL lock_steady got=%0d exp=4", holeNumber); end
      checks++; if (callLocked !== 1'b1) begin errors++; $display("FAIL lock_steady_flag got=%b exp=1", callLocked); end
      drive(0, 0, 0, 0, 0, 0, 1, 3'd4);
      checks++; if (callDone !== 1'b1) begin errors++; $display("FAIL hit_done got=%b exp=1", callDone); end
      checks++; if (callSuccess !== 1'b1) begin errors++; $display("FAIL hit_success got=%b exp=1", callSuccess); end
      checks++; if (callLocked !== 1'b0) begin errors++; $display("FAIL result_unlocked got=%b exp=0", callLocked); end
      drive(0, 0, 0, 0, 0, 0, 0, 3'd0);
      checks++; if (callDone !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b exp=0", callDone); end
      frames(119);
      checks++; if (holeNumber !== 3'd4) begin errors++; $display("FAIL result_119 got=%0d exp=4", holeNumber); end
      frames(1);
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL result_end got=%0d exp=0", holeNumber); end
      checks++; if (callSuccess !== 1'b1) begin errors++; $display("FAIL success_held got=%b exp=1", callSuccess); end
   endtask

   task automatic test_miss;
      drive(0, 1, 0, 0, 0, 0, 0, 3'd0);
      checks++; if (callSuccess !== 1'b0) begin errors++; $display("FAIL req_clears_success got=%b exp=0", callSuccess); end
      drive(0, 0, 0, 0, 1, 0, 0, 3'd0);
      drive(0, 0, 0, 0, 0, 0, 1, 3'd2);
      checks++; if (callDone !== 1'b0) begin errors++; $display("FAIL bp_in_select_done got=%b exp=0", callDone); end
      checks++; if (holeNumber !== 3'd2) begin errors++; $display("FAIL bp_in_select_hole got=%0d exp=2", holeNumber); end
      checks++; if (callLocked !== 1'b0) begin errors++; $display("FAIL bp_in_select_locked got=%b exp=0", callLocked); end
      drive(0, 0, 0, 0, 0, 1, 0, 3'd0);
      drive(0, 0, 0, 0, 0, 0, 1, 3'd5);
      checks++; if (callDone !== 1'b1) begin errors++; $display("FAIL miss_done got=%b exp=1", callDone); end
      checks++; if (callSuccess !== 1'b0) begin errors++; $display("FAIL miss_success got=%b exp=0", callSuccess); end
      frames(120);
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL miss_back_idle got=%0d exp=0", holeNumber); end
   endtask

   task automatic test_priority;
      drive(0, 1, 0, 0, 0, 0, 0, 3'd0);
      repeat (2) drive(0, 0, 0, 0, 1, 0, 0, 3'd0);
      drive(0, 0, 0, 0, 1, 1, 0, 3'd0);
      checks++; if (callLocked !== 1'b1) begin errors++; $display("FAIL enter_right_locked got=%b exp=1", callLocked); end
      checks++; if (holeNumber !== 3'd3) begin errors++; $display("FAIL enter_right_hole got=%0d exp=3", holeNumber); end
      drive(0, 1, 0, 0, 0, 0, 0, 3'd0);
      checks++; if (callLocked !== 1'b1) begin errors++; $display("FAIL req_in_locked got=%b exp=1", callLocked); end
      drive(0, 0, 0, 0, 0, 0, 0, 3'd0);
      drive(0, 0, 1, 0, 0, 0, 0, 3'd0);
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL abort_locked_hole got=%0d exp=0", holeNumber); end
      checks++; if (callLocked !== 1'b0) begin errors++; $display("FAIL abort_locked_flag got=%b exp=0", callLocked); end
      drive(0, 1, 0, 0, 0, 0, 0, 3'd0);
      repeat (2) drive(0, 0, 0, 0, 1, 0, 0, 3'd0);
      drive(0, 0, 0, 1, 1, 0, 0, 3'd0);
      checks++; if (holeNumber !== 3'd3) begin errors++; $display("FAIL left_right_no_move got=%0d exp=3", holeNumber); end
      drive(0, 0, 0, 0, 0, 1, 0, 3'd0);
      drive(0, 0, 0, 0, 0, 0, 1, 3'd7);
      checks++; if (callDone !== 1'b1) begin errors++; $display("FAIL hole7_done got=%b exp=1", callDone); end
      checks++; if (callSuccess !== 1'b0) begin errors++; $display("FAIL hole7_miss got=%b exp=0", callSuccess); end
      frames(120);
   endtask

   task automatic test_abort_reset;
      drive(0, 1, 0, 0, 0, 0, 0, 3'd0);
      drive(0, 0, 0, 0, 0, 1, 0, 3'd0);
      drive(0, 0, 0, 0, 0, 0, 1, 3'd1);
      checks++; if (callSuccess !== 1'b1) begin errors++; $display("FAIL hit1_success got=%b exp=1", callSuccess); end
      drive(0, 0, 1, 0, 0, 0, 0, 3'd0);
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL abort_result_hole got=%0d exp=0", holeNumber); end
      checks++; if (callSuccess !== 1'b1) begin errors++; $display("FAIL abort_keeps_success got=%b exp=1", callSuccess); end
      drive(0, 1, 0, 0, 0, 0, 0, 3'd0);
      drive(0, 0, 0, 0, 0, 1, 0, 3'd0);
      drive(0, 0, 1, 0, 0, 0, 1, 3'd1);
      checks++; if (callDone !== 1'b0) begin errors++; $display("FAIL abort_beats_bp got=%b exp=0", callDone); end
      checks++; if (callLocked !== 1'b0) begin errors++; $display("FAIL abort_lock_flag got=%b exp=0", callLocked); end
      drive(0, 1, 0, 0, 0, 0, 0, 3'd0);
      drive(0, 0, 0, 0, 0, 1, 0, 3'd0);
      drive(0, 0, 0, 0, 0, 0, 1, 3'd1);
      frames(5);
      checks++; if (holeNumber !== 3'd1) begin errors++; $display("FAIL pre_reset_hole got=%0d exp=1", holeNumber); end
      #2;
      resetN = 0;
      #1;
      checks++; if (holeNumber !== 3'd0) begin errors++; $display("FAIL async_hole got=%0d exp=0", holeNumber); end
      checks++; if (callLocked !== 1'b0) begin errors++; $display("FAIL async_locked got=%b exp=0", callLocked); end
      checks++; if (callDone !== 1'b0) begin errors++; $display("FAIL async_done got=%b exp=0", callDone); end
      checks++; if (callSuccess !== 1'b0) begin errors++; $display("FAIL async_success got=%b exp=0", callSuccess); end
      @(negedge clk);
      resetN = 1;
   endtask

   initial begin
      test_reset();
      test_blink();
      test_keys();
      test_hit();
      test_miss();
      test_priority();
      test_abort_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
